pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the fetch program counter for the RV32IM 5-stage pipeline and sequences its update every cycle.
//  Selects next PC: sequential (+4), EX-stage branch/jump redirect, or hold.
//  Arbitrates redirects against instruction-/data-memory busywait and load-use stalls.
//  Generates IF/ID and ID/EX flush/stall controls.
//  Sits between the IF stage (instruction memory), the hazard logic and the EX-stage branch unit.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  BOOT_CYCLES   2              cycles fetch is held off after RESET deasserts (1..15)
// PORTS
//  CLOCK           in   1   rising-edge clock
//  RESET           in   1   synchronous, active-high reset
//  IMEM_BUSYWAIT   in   1   instruction memory not ready; current fetch must be held
//  DMEM_BUSYWAIT   in   1   data memory busy; whole pipeline freezes
//  LOAD_USE_STALL  in   1   hazard unit: hold PC and IF/ID, bubble into ID/EX
//  REDIRECT        in   1   EX-stage taken branch or jump (JAL/JALR) this cycle
//  REDIRECT_TARGET in   32  target address accompanying REDIRECT
//  PC              out  32  current fetch PC (drives IMEM address)
//  IMEM_READ       out  1   fetch request, high while in RUN or WAIT_IMEM
//  FETCH_VALID     out  1   instruction at PC is valid this cycle (IMEM_READ & !IMEM_BUSYWAIT & no flush)
//  PIPE_STALL      out  1   hold enable for PC/IF-ID registers
//  IF_ID_FLUSH     out  1   squash IF/ID contents
//  ID_EX_FLUSH     out  1   insert bubble into ID/EX
//  MISALIGN_ERR    out  1   one-cycle pulse: redirect target[1:0]!=0
// BEHAVIOUR
//  Reset (RESET=1 at edge): PC=RESET_VECTOR, state=BOOT, boot counter=0.
//   Outputs during reset: IMEM_READ=0, FETCH_VALID=0, PIPE_STALL=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, MISALIGN_ERR=0.
//   Pending-redirect register cleared.
//  States: BOOT, RUN, WAIT_IMEM, REDIR_PEND.
//  BOOT: count to BOOT_CYCLES-1, then -> RUN. Flush outputs stay high. REDIRECT is ignored.
//  RUN, priority per cycle (highest first):
//   1 DMEM_BUSYWAIT: PC held; PIPE_STALL=1; no flush. A REDIRECT this cycle is latched to pending, state -> REDIR_PEND.
//   2 REDIRECT: if IMEM_BUSYWAIT=0, PC<=target&~3 next edge; IF_ID_FLUSH=ID_EX_FLUSH=1 this cycle.
//     If IMEM_BUSYWAIT=1, latch target, assert both flushes, -> REDIR_PEND.
//   3 LOAD_USE_STALL: PC held; PIPE_STALL=1; ID_EX_FLUSH=1.
//   4 IMEM_BUSYWAIT: PC held; PIPE_STALL=1; -> WAIT_IMEM.
//   5 else: PC<=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
//  WAIT_IMEM: PC held, PIPE_STALL=1. IMEM_BUSYWAIT=0 -> RUN, PC<=PC+4 same edge.
//   REDIRECT here behaves as in RUN with IMEM busy (-> REDIR_PEND).
//  REDIR_PEND: PC held, IF_ID_FLUSH=1 every cycle.
//   When IMEM_BUSYWAIT=0 and DMEM_BUSYWAIT=0: PC<=pending, -> RUN.
//   A newer REDIRECT overwrites pending (youngest wins).
//  Redirect latency: 1 cycle (PC shows target the cycle after REDIRECT when unblocked).
//  MISALIGN_ERR pulses in the cycle REDIRECT is accepted/latched with target[1:0]!=0. Target still applied with [1:0] cleared.
//  Simultaneous REDIRECT+LOAD_USE_STALL: redirect wins (stalled instruction is on the wrong path).
//  RESET mid-operation (any state) overrides everything in the same edge; pending redirect discarded.
//  FETCH_VALID=0 whenever IF_ID_FLUSH=1 or in BOOT/REDIR_PEND.
// STRUCTURE
//  Shared package pipe_pkg: state encoding typedef (BOOT/RUN/WAIT_IMEM/REDIR_PEND), XLEN=32, PC_STEP=4.
//  One natural sub-module: pc_reg (32-bit PC register with hold enable and sync load of RESET_VECTOR).
//  Next-PC mux and FSM stay in pc_sequencer.
// TESTING
//  1 Reset then release, no busy: PC=0 through BOOT (2 cycles), then 0,4,8,C on successive edges; FETCH_VALID high from first RUN cycle.
//  2 REDIRECT=1, target=0x100 at PC=0x20, IMEM idle: flushes high that cycle; PC=0x100 next cycle, then 0x104.
//  3 IMEM_BUSYWAIT high 3 cycles at PC=0x40 with REDIRECT to 0x200 in cycle 2:
//    PC stays 0x40; IF_ID_FLUSH high from cycle 2; PC=0x200 the cycle after busy drops.
//  4 LOAD_USE_STALL 1 cycle at PC=0x10: PC holds 0x10, ID_EX_FLUSH=1, PIPE_STALL=1; next cycle PC=0x14.
//  5 REDIRECT target=0x102: MISALIGN_ERR pulses once; PC becomes 0x100. PC=0xFFFF_FFFC sequential step -> 0x0.
//  6 RESET asserted in REDIR_PEND (pending=0x300): PC=RESET_VECTOR next edge; after BOOT, fetch resumes at 0 (not 0x300).

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_sequencer_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT_IMEM,
    ST_REDIR_PEND
  } pc_state_t;

  // Instruction fetch is word-addressed; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and the IF stage, hazard unit and branch unit.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic            IMEM_BUSYWAIT;
  logic            DMEM_BUSYWAIT;
  logic            LOAD_USE_STALL;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_TARGET;
  logic [XLEN-1:0] PC;
  logic            IMEM_READ;
  logic            FETCH_VALID;
  logic            PIPE_STALL;
  logic            IF_ID_FLUSH;
  logic            ID_EX_FLUSH;
  logic            MISALIGN_ERR;
  pc_state_t       state;

  // No valid/ready pairs here: every input is a level sampled each cycle and
  // every output is a per-cycle qualifier; REDIRECT is accepted the cycle it is high.
  modport master (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, LOAD_USE_STALL, REDIRECT, REDIRECT_TARGET,
    output PC, IMEM_READ, FETCH_VALID, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
           MISALIGN_ERR, state
  );

  modport slave (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, LOAD_USE_STALL, REDIRECT, REDIRECT_TARGET,
    input  PC, IMEM_READ, FETCH_VALID, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH,
           MISALIGN_ERR, state
  );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// Fetch PC register: loads RESET_VECTOR on reset, otherwise holds unless hold is low.
module pc_sequencer_pc_reg
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge CLOCK) begin
    if (RESET)      pc <= RESET_VECTOR;
    else if (!hold) pc <= pc_next;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: next-PC selection, redirect/stall arbitration and IF/ID, ID/EX flush control.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic           CLOCK,
  input  logic           RESET,
  pc_sequencer_if.master bus
);

  pc_state_t       state, state_next;
  logic [3:0]      boot_cnt;
  logic [XLEN-1:0] pending, pending_next;
  logic [XLEN-1:0] pc, pc_next, redir_tgt;
  logic            pc_load, imem_read, if_flush, ex_flush, misalign, redir_mis;

  assign redir_tgt = align_word(bus.REDIRECT_TARGET);
  assign redir_mis = |bus.REDIRECT_TARGET[1:0];

  always_comb begin
    state_next   = state;
    pending_next = pending;
    pc_load      = 1'b0;
    pc_next      = pc + PC_STEP;
    imem_read    = 1'b0;
    if_flush     = 1'b0;
    ex_flush     = 1'b0;
    misalign     = 1'b0;
    case (state)
      ST_BOOT: begin
        if_flush = 1'b1;
        ex_flush = 1'b1;
        if (boot_cnt == 4'(BOOT_CYCLES - 1)) state_next = ST_RUN;
      end
      ST_RUN, ST_WAIT_IMEM: begin
        imem_read = 1'b1;
        if (bus.DMEM_BUSYWAIT) begin
          // Frozen pipeline: a redirect is remembered but the flush waits for REDIR_PEND.
          if (bus.REDIRECT) begin
            pending_next = redir_tgt;
            misalign     = redir_mis;
            state_next   = ST_REDIR_PEND;
          end
        end else if (bus.REDIRECT) begin
          if_flush = 1'b1;
          ex_flush = 1'b1;
          misalign = redir_mis;
          if (state == ST_RUN && !bus.IMEM_BUSYWAIT) begin
            pc_load = 1'b1;
            pc_next = redir_tgt;
          end else begin
            pending_next = redir_tgt;
            state_next   = ST_REDIR_PEND;
          end
        end else if (state == ST_WAIT_IMEM) begin
          if (!bus.IMEM_BUSYWAIT) begin
            state_next = ST_RUN;
            if (bus.LOAD_USE_STALL) ex_flush = 1'b1;
            else                    pc_load  = 1'b1;
          end
        end else if (bus.LOAD_USE_STALL) begin
          ex_flush = 1'b1;
        end else if (bus.IMEM_BUSYWAIT) begin
          state_next = ST_WAIT_IMEM;
        end else begin
          pc_load = 1'b1;
        end
      end
      ST_REDIR_PEND: begin
        if_flush = 1'b1;
        if (bus.REDIRECT) begin
          pending_next = redir_tgt;
          misalign     = redir_mis;
          ex_flush     = 1'b1;
        end
        if (!bus.IMEM_BUSYWAIT && !bus.DMEM_BUSYWAIT) begin
          pc_load    = 1'b1;
          pc_next    = bus.REDIRECT ? redir_tgt : pending;
          state_next = ST_RUN;
        end
      end
    endcase
    if (RESET) begin
      pc_load   = 1'b0;
      imem_read = 1'b0;
      if_flush  = 1'b1;
      ex_flush  = 1'b1;
      misalign  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      pending  <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      boot_cnt <= (state == ST_BOOT && state_next == ST_BOOT) ? boot_cnt + 4'd1 : '0;
    end
  end

  pc_sequencer_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .hold    (!pc_load),
    .pc_next (pc_next),
    .pc      (pc)
  );

  assign bus.PC           = pc;
  assign bus.IMEM_READ    = imem_read;
  assign bus.FETCH_VALID  = imem_read && !bus.IMEM_BUSYWAIT && !if_flush;
  assign bus.PIPE_STALL   = !pc_load;
  assign bus.IF_ID_FLUSH  = if_flush;
  assign bus.ID_EX_FLUSH  = ex_flush;
  assign bus.MISALIGN_ERR = misalign;
  assign bus.state        = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expected PC and control flags through a scoreboard queue.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int W = XLEN + 6;
  // Flag order: {IMEM_READ, FETCH_VALID, PIPE_STALL, IF_ID_FLUSH, ID_EX_FLUSH, MISALIGN_ERR}
  localparam logic [5:0] F_RESET     = 6'b001110;
  localparam logic [5:0] F_BOOT      = 6'b001110;
  localparam logic [5:0] F_RUN       = 6'b110000;
  localparam logic [5:0] F_REDIR     = 6'b100110;
  localparam logic [5:0] F_REDIR_MIS = 6'b100111;
  localparam logic [5:0] F_LOAD_USE  = 6'b111010;
  localparam logic [5:0] F_IMEM_BUSY = 6'b101000;
  localparam logic [5:0] F_DMEM_BUSY = 6'b111000;
  localparam logic [5:0] F_BUSY_REDIR= 6'b101110;
  localparam logic [5:0] F_PEND_HOLD = 6'b001100;
  localparam logic [5:0] F_PEND_EXIT = 6'b000100;

  logic CLOCK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .BOOT_CYCLES(2)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic drive(input logic imem, input logic dmem, input logic lu,
                       input logic redir, input logic [31:0] tgt);
    bus.IMEM_BUSYWAIT   = imem;
    bus.DMEM_BUSYWAIT   = dmem;
    bus.LOAD_USE_STALL  = lu;
    bus.REDIRECT        = redir;
    bus.REDIRECT_TARGET = tgt;
  endtask

  // Push the expectation for the current cycle, compare on the falling edge, then advance.
  task automatic tick(input string tag, input logic [31:0] pc, input logic [5:0] flags);
    logic [W-1:0] got, exp;
    exp_q.push_back({pc, flags});
    @(negedge CLOCK);
    got = {bus.PC, bus.IMEM_READ, bus.FETCH_VALID, bus.PIPE_STALL,
           bus.IF_ID_FLUSH, bus.ID_EX_FLUSH, bus.MISALIGN_ERR};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed pc=%h flags=%b expected pc=%h flags=%b",
             tag, got[W-1:6], got[5:0], exp[W-1:6], exp[5:0]);
    end
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge CLOCK);
    #1;
    tick("reset", 32'h0, F_RESET);
    RESET = 1'b0;

    // Boot then sequential fetch
    tick("boot0", 32'h0, F_BOOT);
    tick("boot1", 32'h0, F_BOOT);
    for (int i = 0; i < 4; i++) tick("seq", 32'(i * 4), F_RUN);

    // Load-use stall at 0x10
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick("load_use", 32'h10, F_LOAD_USE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("lu_release", 32'h10, F_RUN);
    for (int i = 0; i < 3; i++) tick("seq2", 32'h14 + 32'(i * 4), F_RUN);

    // Redirect at 0x20 to 0x100, IMEM idle
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    tick("redir", 32'h20, F_REDIR);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("redir_tgt", 32'h100, F_RUN);
    tick("redir_seq", 32'h104, F_RUN);

    // Reach 0x40, then IMEM busy 3 cycles with redirect in cycle 2
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    tick("redir40", 32'h108, F_REDIR);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("ibusy1", 32'h40, F_IMEM_BUSY);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    tick("ibusy2_redir", 32'h40, F_BUSY_REDIR);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("ibusy3", 32'h40, F_PEND_HOLD);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("pend_exit", 32'h40, F_PEND_EXIT);
    tick("pend_tgt", 32'h200, F_RUN);

    // Misaligned redirect, then wrap at top of address space
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
    tick("misalign", 32'h204, F_REDIR_MIS);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("mis_tgt", 32'h100, F_RUN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick("redir_top", 32'h104, F_REDIR);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("top", 32'hFFFF_FFFC, F_RUN);
    tick("wrap", 32'h0, F_RUN);
    tick("wrap_seq", 32'h4, F_RUN);

    // DMEM freeze, then DMEM freeze with redirect latched
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick("dbusy", 32'h8, F_DMEM_BUSY);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h50);
    tick("dbusy_redir", 32'h8, F_DMEM_BUSY);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("dbusy_exit", 32'h8, F_PEND_EXIT);
    tick("dbusy_tgt", 32'h50, F_RUN);

    // Redirect and load-use together: redirect wins
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick("redir_lu", 32'h54, F_REDIR);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("redir_lu_tgt", 32'h80, F_RUN);

    // Reset while a redirect to 0x300 is pending
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    tick("pend300", 32'h84, F_BUSY_REDIR);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("pend300_hold", 32'h84, F_PEND_HOLD);
    RESET = 1'b1;
    tick("mid_reset", 32'h84, F_RESET);
    RESET = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("reboot0", 32'h0, F_BOOT);
    tick("reboot1", 32'h0, F_BOOT);
    tick("resume0", 32'h0, F_RUN);
    tick("resume4", 32'h4, F_RUN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
